// File: rtl/alu_pkg.sv
// alu_pkg: shared flag layout and saturation bounds for the ALU result path.
// Contents: FLAG_* bit indices into flags_t ({N,Z,C,V}), flags_t typedef,
// SAT_MAX_FULL/SAT_MIN_FULL bounds whose top WIDTH bits give the signed
// max/min for any WIDTH up to 64.
package alu_pkg;
    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;
    typedef logic [3:0] flags_t;
    localparam logic [63:0] SAT_MAX_FULL = 64'h7FFF_FFFF_FFFF_FFFF;
    localparam logic [63:0] SAT_MIN_FULL = 64'h8000_0000_0000_0000;
endpackage

// File: rtl/alu_flag_calc.sv
// alu_flag_calc: combinational flag generation and optional saturation.
// Ports: sum/cout from the adder-subtractor, sub (1 = a-b), a_msb/b_msb
// operand signs; result = final word, flags = {N,Z,C,V} of that word.
// Build option: ALU_SATURATE_EN clamps overflowed results to min/max.
import alu_pkg::*;
module alu_flag_calc #(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] sum,
    input  logic             cout,
    input  logic             sub,
    input  logic             a_msb,
    input  logic             b_msb,
    output logic [WIDTH-1:0] result,
    output flags_t           flags
);
    logic v;
    logic c;
    // Subtraction flips the effective sign of b, so overflow needs differing signs.
    assign v = (sub ? (a_msb != b_msb) : (a_msb == b_msb)) & (sum[WIDTH-1] != a_msb);
    // The adder reports carry; subtraction reports borrow, its inverse.
    assign c = cout ^ sub;
`ifdef ALU_SATURATE_EN
    // On overflow the true result has the sign of a, so clamp toward it.
    assign result = v ? (a_msb ? SAT_MIN_FULL[63 -: WIDTH] : SAT_MAX_FULL[63 -: WIDTH]) : sum;
`else
    assign result = sum;
`endif
    always_comb begin
        flags         = '0;
        flags[FLAG_N] = result[WIDTH-1];
        flags[FLAG_Z] = (result == '0);
        flags[FLAG_C] = c;
        flags[FLAG_V] = v;
    end
endmodule

// File: rtl/alu_result_stage.sv
// alu_result_stage: 2-entry buffered result stage with flags and sticky overflow.
// Ports: clk, rst (async, active-high); in_valid/in_ready/in_sum/in_cout/in_sub/
// in_a_msb/in_b_msb upstream; out_valid/out_ready/out_result/out_flags
// downstream; clr_sticky/sticky_v overflow history.
// Build option: ALU_SATURATE_EN (forwarded to alu_flag_calc).
import alu_pkg::*;
module alu_result_stage #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_sum,
    input  logic             in_cout,
    input  logic             in_sub,
    input  logic             in_a_msb,
    input  logic             in_b_msb,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output flags_t           out_flags,
    input  logic             clr_sticky,
    output logic             sticky_v
);
    logic [WIDTH-1:0] res;
    flags_t           flg;
    logic [WIDTH-1:0] res_mem [2];
    flags_t           flg_mem [2];
    logic             wr_ptr;
    logic             rd_ptr;
    logic [1:0]       count;
    logic             push;
    logic             pop;

    alu_flag_calc #(.WIDTH(WIDTH)) u_calc (
        .sum    (in_sum),
        .cout   (in_cout),
        .sub    (in_sub),
        .a_msb  (in_a_msb),
        .b_msb  (in_b_msb),
        .result (res),
        .flags  (flg)
    );

    assign in_ready   = ~count[1];
    assign out_valid  = |count;
    assign push       = in_valid & in_ready;
    assign pop        = out_valid & out_ready;
    // Gating by out_valid keeps stale storage invisible after reset or drain.
    assign out_result = out_valid ? res_mem[rd_ptr] : '0;
    assign out_flags  = out_valid ? flg_mem[rd_ptr] : '0;

    always_ff @(posedge clk) begin
        if (push) begin
            res_mem[wr_ptr] <= res;
            flg_mem[wr_ptr] <= flg;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr   <= 1'b0;
            rd_ptr   <= 1'b0;
            count    <= 2'd0;
            sticky_v <= 1'b0;
        end else begin
            wr_ptr   <= wr_ptr ^ push;
            rd_ptr   <= rd_ptr ^ pop;
            count    <= count + 2'(push) - 2'(pop);
            // A new overflow outranks a same-cycle clear.
            sticky_v <= (push & flg[FLAG_V]) | (sticky_v & ~clr_sticky);
        end
    end
endmodule

// File: tb/tb_alu_result_stage.sv
// tb_alu_result_stage: vector table, directed corner sequences and a random
// scoreboard run against an arithmetic reference model.
module tb_alu_result_stage;
    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_sum;
    logic        in_cout;
    logic        in_sub;
    logic        in_a_msb;
    logic        in_b_msb;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_result;
    logic [3:0]  out_flags;
    logic        clr_sticky;
    logic        sticky_v;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        sub;
        logic [15:0] r;
        logic [3:0]  f;
    } vec_t;

    typedef struct {
        logic [15:0] r;
        logic [3:0]  f;
    } exp_t;

    alu_result_stage #(.WIDTH(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_sum     (in_sum),
        .in_cout    (in_cout),
        .in_sub     (in_sub),
        .in_a_msb   (in_a_msb),
        .in_b_msb   (in_b_msb),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_flags  (out_flags),
        .clr_sticky (clr_sticky),
        .sticky_v   (sticky_v)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Upstream adder-subtractor: a + (sub ? ~b : b) + sub.
    task automatic drive(input logic [15:0] a, input logic [15:0] b, input logic sub);
        logic [16:0] t;
        t        = {1'b0, a} + {1'b0, sub ? ~b : b} + 17'(sub);
        in_sum   = t[15:0];
        in_cout  = t[16];
        in_sub   = sub;
        in_a_msb = a[15];
        in_b_msb = b[15];
    endtask

    // Reference: exact integer arithmetic, overflow = out of signed range.
    function automatic exp_t ref_calc(input logic [15:0] a, input logic [15:0] b, input logic sub);
        exp_t e;
        int   t;
        logic v;
        logic c;
        t = sub ? int'($signed(a)) - int'($signed(b)) : int'($signed(a)) + int'($signed(b));
        v = (t > 32767) || (t < -32768);
        c = sub ? (a < b) : ((int'(a) + int'(b)) > 65535);
        e.r = t[15:0];
`ifdef ALU_SATURATE_EN
        if (v) e.r = (t < 0) ? 16'h8000 : 16'h7FFF;
`endif
        e.f = {e.r[15], e.r == 16'h0, c, v};
        return e;
    endfunction

    initial begin
        vec_t vt[7];
        exp_t q[$];
        exp_t e;
        logic sticky_m;
        logic [15:0] a;
        logic [15:0] b;
        logic sub;
        logic push;
        logic pop;

        vt[0] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 4'b1001};
        vt[1] = '{16'h0005, 16'h0005, 1'b1, 16'h0000, 4'b0100};
        vt[2] = '{16'h0001, 16'h0002, 1'b0, 16'h0003, 4'b0000};
        vt[3] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 4'b0110};
        vt[4] = '{16'h8000, 16'h0001, 1'b1, 16'h7FFF, 4'b0001};
        vt[5] = '{16'h0003, 16'h0005, 1'b1, 16'hFFFE, 4'b1010};
        vt[6] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 4'b0111};
`ifdef ALU_SATURATE_EN
        vt[0].r = 16'h7FFF; vt[0].f = 4'b0001;
        vt[4].r = 16'h8000; vt[4].f = 4'b1001;
        vt[6].r = 16'h8000; vt[6].f = 4'b1011;
`endif

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; clr_sticky = 1'b0;
        drive(16'h0, 16'h0, 1'b0);
        step();
        step();
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_out_result", out_result, 16'h0);
        chk("rst_out_flags", out_flags, 4'h0);
        chk("rst_sticky", sticky_v, 1'b0);
        rst = 1'b0;
        step();
        chk("rst_in_ready", in_ready, 1'b1);

        sticky_m = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 7; i++) begin
            chk("tbl_pre_valid", out_valid, 1'b0);
            in_valid = 1'b1;
            drive(vt[i].a, vt[i].b, vt[i].sub);
            step();
            in_valid = 1'b0;
            sticky_m |= vt[i].f[0];
            chk($sformatf("tbl%0d_valid", i), out_valid, 1'b1);
            chk($sformatf("tbl%0d_result", i), out_result, vt[i].r);
            chk($sformatf("tbl%0d_flags", i), out_flags, vt[i].f);
            chk($sformatf("tbl%0d_sticky", i), sticky_v, sticky_m);
            step();
        end

        // Backpressure: three back-to-back words with downstream stalled.
        out_ready = 1'b0;
        in_valid = 1'b1;
        drive(16'h0010, 16'h0001, 1'b0);
        step();
        chk("bp_ready1", in_ready, 1'b1);
        chk("bp_head1", out_result, 16'h0011);
        drive(16'h0020, 16'h0002, 1'b0);
        step();
        chk("bp_ready2", in_ready, 1'b0);
        chk("bp_valid2", out_valid, 1'b1);
        drive(16'h0030, 16'h0003, 1'b1);
        step();
        chk("bp_ready3", in_ready, 1'b0);
        chk("bp_hold_result", out_result, 16'h0011);
        chk("bp_hold_flags", out_flags, 4'h0);
        out_ready = 1'b1;
        step();
        chk("bp_out_b", out_result, 16'h0022);
        chk("bp_ready4", in_ready, 1'b1);
        // Occupancy 1: third word pushes while second pops.
        step();
        in_valid = 1'b0;
        chk("pp_out_c", out_result, 16'h002D);
        chk("pp_valid", out_valid, 1'b1);
        chk("pp_ready", in_ready, 1'b1);
        step();
        chk("pp_drained", out_valid, 1'b0);

        // Clear coinciding with an overflowing push: set wins.
        clr_sticky = 1'b1;
        step();
        chk("clr_sticky", sticky_v, 1'b0);
        in_valid = 1'b1;
        drive(16'h7FFF, 16'h0001, 1'b0);
        step();
        in_valid = 1'b0;
        chk("clr_vs_set", sticky_v, 1'b1);
        step();
        clr_sticky = 1'b0;
        chk("clr_after", sticky_v, 1'b0);
        step();

        // Reset with two words buffered.
        out_ready = 1'b0;
        in_valid = 1'b1;
        drive(16'h7FFF, 16'h0001, 1'b0);
        step();
        drive(16'h1234, 16'h0001, 1'b0);
        step();
        in_valid = 1'b0;
        chk("mr_full", in_ready, 1'b0);
        chk("mr_sticky_pre", sticky_v, 1'b1);
        #2 rst = 1'b1;
        #1;
        chk("mr_valid", out_valid, 1'b0);
        chk("mr_result", out_result, 16'h0);
        chk("mr_flags", out_flags, 4'h0);
        chk("mr_sticky", sticky_v, 1'b0);
        step();
        rst = 1'b0;
        out_ready = 1'b1;
        step();
        step();
        chk("mr_no_stale", out_valid, 1'b0);
        chk("mr_ready", in_ready, 1'b1);

        // Random traffic against a queue-based scoreboard.
        q.delete();
        sticky_m = 1'b0;
        for (int n = 0; n < 2000; n++) begin
            chk("rnd_in_ready", in_ready, q.size() < 2);
            chk("rnd_out_valid", out_valid, q.size() > 0);
            if (q.size() > 0) begin
                chk("rnd_result", out_result, q[0].r);
                chk("rnd_flags", out_flags, q[0].f);
            end
            chk("rnd_sticky", sticky_v, sticky_m);
            in_valid   = $urandom_range(0, 3) != 0;
            out_ready  = $urandom_range(0, 2) != 0;
            clr_sticky = $urandom_range(0, 15) == 0;
            a = 16'($urandom);
            b = 16'($urandom);
            if ($urandom_range(0, 7) == 0) a = {a[15], 15'h7FFF};
            sub = 1'($urandom);
            drive(a, b, sub);
            e = ref_calc(a, b, sub);
            push = in_valid && (q.size() < 2);
            pop  = out_ready && (q.size() > 0);
            step();
            if (pop) void'(q.pop_front());
            if (push) q.push_back(e);
            sticky_m = (push && e.f[0]) || (sticky_m && !clr_sticky);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/alu_result_stage.md
ALU_RESULT_STAGE -- requirements
Module: alu_result_stage

Interface
REQ-001 SHALL have parameter WIDTH, default 16, datapath width in bits.
REQ-002 SHALL have port clk  input  1  rising-edge clock, the single clock.
REQ-003 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port in_valid  input  1  upstream sum/carry word present.
REQ-005 SHALL have port in_ready  output  1  stage can accept a word this cycle.
REQ-006 SHALL have port in_sum  input  WIDTH  adder-subtractor sum s.
REQ-007 SHALL have port in_cout  input  1  adder-subtractor carry-out.
REQ-008 SHALL have port in_sub  input  1  enable used for this word (1 = a-b, 0 = a+b).
REQ-009 SHALL have port in_a_msb, in_b_msb  input  1 each  operand sign bits for this word.
REQ-010 SHALL have port out_valid  output  1  result word present.
REQ-011 SHALL have port out_ready  input  1  downstream accepts result.
REQ-012 SHALL have port out_result  output  WIDTH  final result.
REQ-013 SHALL have port out_flags  output  4  {N,Z,C,V} for out_result.
REQ-014 SHALL have port clr_sticky  input  1  clears sticky overflow.
REQ-015 SHALL have port sticky_v  output  1  overflow seen on any accepted word since reset/clear.

Function
REQ-016 SHALL hold accepted words in a 2-entry FIFO; push = in_valid & in_ready, pop = out_valid & out_ready.
REQ-017 SHALL drive in_ready = (occupancy < 2), independent of in_valid and out_ready (no combinational ready path).
REQ-018 SHALL present a word pushed at edge t on out_valid/out_result/out_flags from t+1 (latency 1 when empty).
REQ-019 SHALL hold out_result and out_flags stable while out_valid=1 and out_ready=0.
REQ-020 SHALL allow simultaneous push and pop at occupancy 1: occupancy stays 1, new word follows the popped word.
REQ-021 SHALL preserve order; no drops, no duplicates; out_valid = (occupancy > 0).
REQ-022 SHALL compute V: add -> (a_msb==b_msb) & (sum_msb!=a_msb); sub -> (a_msb!=b_msb) & (sum_msb!=a_msb).
REQ-023 SHALL compute C: add -> in_cout; sub -> ~in_cout (borrow).
REQ-024 SHALL compute N = result MSB and Z = (result == 0), both on the final (post-saturation) result.
REQ-025 SHALL compute flags at push time and store them with the word.
REQ-026 SHALL set sticky_v at the edge a word with V=1 is pushed; clr_sticky clears it; simultaneous set and clear -> set wins.
REQ-027 SHALL ignore in_* when in_valid=0 or in_ready=0.

Reset
REQ-028 SHALL on rst, asynchronously: occupancy 0, out_valid 0, out_result 0, out_flags 0, sticky_v 0, in_ready 1 once rst deasserts.
REQ-029 SHALL discard buffered words when rst asserts mid-operation; no output after release until a new push.

Configuration
REQ-030 SHALL, with ALU_SATURATE_EN defined, replace result on V=1 with a_msb ? 0x8000 : 0x7FFF (WIDTH-scaled min/max); V still reported as 1.
REQ-031 SHALL, without ALU_SATURATE_EN, pass in_sum unmodified (wrap-around).

Structure
REQ-032 SHALL place flag index constants (FLAG_N=3, FLAG_Z=2, FLAG_C=1, FLAG_V=0), the flags typedef and the saturation min/max constants in shared package alu_pkg.
REQ-033 SHALL put flag and saturation logic in combinational sub-module alu_flag_calc; FIFO and sticky logic stay in alu_result_stage.

Verification
REQ-034 SHALL cover add 0x7FFF+0x0001 (sum 0x8000, cout 0, a_msb 0, b_msb 0) -> flags V=1,N=1,C=0; result 0x8000 without macro, 0x7FFF with ALU_SATURATE_EN (N=0); sticky_v=1.
REQ-035 SHALL cover sub 0x0005-0x0005 (sum 0x0000, cout 1) -> result 0x0000, Z=1, C=0, V=0, out_valid 1 cycle after push.
REQ-036 SHALL cover out_ready=0 with 3 back-to-back pushes -> in_ready drops after 2nd push, 3rd held upstream; release out_ready -> words emerge in order, none lost.
REQ-037 SHALL cover occupancy 1 with simultaneous push and pop -> occupancy stays 1, next out_result is the new word.
REQ-038 SHALL cover clr_sticky asserted in the same cycle as a V=1 push -> sticky_v=1 afterwards.
REQ-039 SHALL cover rst asserted with 2 words buffered -> out_valid 0 immediately, outputs 0, no stale word after release.
